// File: rtl/aes_subshift_stage_if.sv
// aes_subshift_stage_if
//   Handshake and data bundle between an upstream state producer, the
//   SubBytes+ShiftRows stage and the downstream MixColumns consumer.
//   Signals:
//     in_valid / in_ready       : input-side valid/ready handshake
//     statew1..statew4          : input state columns 0..3, [31:24]=row 0
//     out_valid / out_ready     : output-side valid/ready handshake
//     new_statew1..new_statew4  : result columns 0..3, same byte order
//   Modports:
//     slave  : the stage itself
//     master : the environment (producer + consumer side)
interface aes_subshift_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] statew1;
  logic [31:0] statew2;
  logic [31:0] statew3;
  logic [31:0] statew4;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] new_statew1;
  logic [31:0] new_statew2;
  logic [31:0] new_statew3;
  logic [31:0] new_statew4;

  modport slave (
    input  in_valid, statew1, statew2, statew3, statew4, out_ready,
    output in_ready, out_valid, new_statew1, new_statew2, new_statew3, new_statew4
  );

  modport master (
    output in_valid, statew1, statew2, statew3, statew4, out_ready,
    input  in_ready, out_valid, new_statew1, new_statew2, new_statew3, new_statew4
  );
endinterface

// File: rtl/aes_subshift_stage.sv
// aes_subshift_stage
//   Iterative AES SubBytes + ShiftRows stage feeding MixColumns.
//   A captured 128-bit state is substituted COLS_PER_CYCLE columns per
//   cycle through shared S-boxes; the ShiftRows-permuted result is then
//   held on registered outputs until the consumer accepts it.
//   Parameters:
//     COLS_PER_CYCLE : columns substituted per cycle (1, 2 or 4)
//   Ports:
//     clk : clock, rising edge
//     rst : synchronous active-high reset
//     bus : aes_subshift_stage_if.slave (handshakes, state in, result out)
module aes_subshift_stage #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  aes_subshift_stage_if.slave  bus
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("aes_subshift_stage: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // FIPS-197 S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x sits at bit offset (255 - x) * 8, i.e. {~x, 3'b000}.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Output column c, row r takes column (c + r) mod 4, row r.
  function automatic logic [3:0][31:0] shift_rows(input logic [3:0][31:0] s);
    logic [3:0][31:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o[c][31-8*r -: 8] = s[2'(c + r)][31-8*r -: 8];
      end
    end
    return o;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SUB,
    ST_DONE
  } state_t;

  state_t            r_state;
  logic [1:0]        r_col;
  logic [3:0][31:0]  r_cols;
  logic              r_out_valid;
  logic [3:0][31:0]  r_new;

  logic [1:0]        w_col_idx [COLS_PER_CYCLE];
  logic [31:0]       w_sub_col [COLS_PER_CYCLE];
  logic [3:0][31:0]  w_next_cols;
  logic              w_last;

  // Shared S-box bank: 4 S-boxes per column processed this cycle. r_col is
  // always a multiple of COLS_PER_CYCLE, so r_col + g never wraps.
  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign w_col_idx[g] = r_col + 2'(g);
    assign w_sub_col[g] = sub_word(r_cols[w_col_idx[g]]);
  end

  always_comb begin
    w_next_cols = r_cols;
    for (int unsigned g = 0; g < COLS_PER_CYCLE; g++) begin
      w_next_cols[w_col_idx[g]] = w_sub_col[g];
    end
  end

  assign w_last = (r_col == 2'(4 - COLS_PER_CYCLE));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_col       <= '0;
      r_cols      <= '0;
      r_out_valid <= 1'b0;
      r_new       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_cols  <= {bus.statew4, bus.statew3, bus.statew2, bus.statew1};
            r_col   <= '0;
            r_state <= ST_SUB;
          end
        end
        ST_SUB: begin
          r_cols <= w_next_cols;
          r_col  <= r_col + 2'(COLS_PER_CYCLE);
          if (w_last) begin
            // Result is permuted straight from the final substituted state
            // so the outputs are registered on DONE entry.
            r_col       <= '0;
            r_new       <= shift_rows(w_next_cols);
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_new       <= '0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_new       <= '0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready    = (r_state == ST_IDLE) && !rst;
  assign bus.out_valid   = r_out_valid;
  assign bus.new_statew1 = r_new[0];
  assign bus.new_statew2 = r_new[1];
  assign bus.new_statew3 = r_new[2];
  assign bus.new_statew4 = r_new[3];

endmodule

// File: tb/tb_aes_subshift_stage.sv
// tb_aes_subshift_stage
//   Self-checking bench for aes_subshift_stage at COLS_PER_CYCLE = 1, 2, 4.
//   The reference S-box is derived from GF(2^8) inversion plus the affine
//   map; ShiftRows is applied on a byte matrix.
module tb_aes_subshift_stage;

  typedef logic [3:0][31:0] vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] sref [256];

  aes_subshift_stage_if bus1 ();
  aes_subshift_stage_if bus2 ();
  aes_subshift_stage_if bus4 ();

  aes_subshift_stage #(.COLS_PER_CYCLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  aes_subshift_stage #(.COLS_PER_CYCLE(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
  aes_subshift_stage #(.COLS_PER_CYCLE(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    if (a == 8'h00) return 8'h00;
    for (int b = 1; b < 256; b++) begin
      if (gmul(a, 8'(b)) == 8'h01) return 8'(b);
    end
    return 8'h00;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  task automatic build_sref();
    for (int i = 0; i < 256; i++) sref[i] = affine(ginv(8'(i)));
  endtask

  function automatic vec_t model(input vec_t in);
    logic [7:0] m [4][4];
    vec_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        m[c][r] = in[c][31-8*r -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[c][31-8*r -: 8] = sref[m[(c + r) % 4][r]];
    return o;
  endfunction

  function automatic vec_t mk(input logic [31:0] w1, input logic [31:0] w2,
                              input logic [31:0] w3, input logic [31:0] w4);
    return {w4, w3, w2, w1};
  endfunction

  function automatic vec_t get1();
    return {bus1.new_statew4, bus1.new_statew3, bus1.new_statew2, bus1.new_statew1};
  endfunction
  function automatic vec_t get2();
    return {bus2.new_statew4, bus2.new_statew3, bus2.new_statew2, bus2.new_statew1};
  endfunction
  function automatic vec_t get4();
    return {bus4.new_statew4, bus4.new_statew3, bus4.new_statew2, bus4.new_statew1};
  endfunction

  function automatic vec_t rand_vec();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  vec_t VEC_A_IN, VEC_A_OUT;

  // ---------------- stimulus helpers (no checks) ----------------
  task automatic idle_all();
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.out_ready = 1'b0;
    bus4.in_valid = 1'b0; bus4.out_ready = 1'b0;
    {bus1.statew4, bus1.statew3, bus1.statew2, bus1.statew1} = '0;
    {bus2.statew4, bus2.statew3, bus2.statew2, bus2.statew1} = '0;
    {bus4.statew4, bus4.statew3, bus4.statew2, bus4.statew1} = '0;
  endtask

  // Returns at the negedge following the accepting edge.
  task automatic send1(input vec_t v);
    @(negedge clk);
    {bus1.statew4, bus1.statew3, bus1.statew2, bus1.statew1} = v;
    bus1.in_valid = 1'b1;
    @(negedge clk);
    bus1.in_valid = 1'b0;
  endtask

  task automatic wait_valid1(output int k);
    k = 0;
    while (!bus1.out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic consume1();
    bus1.out_ready = 1'b1;
    @(negedge clk);
    bus1.out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle_all();
    repeat (3) @(negedge clk);
    checks++;
    if ({bus1.in_ready, bus2.in_ready, bus4.in_ready} !== 3'b000) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 000", {bus1.in_ready, bus2.in_ready, bus4.in_ready});
    end
    checks++;
    if ({bus1.out_valid, bus2.out_valid, bus4.out_valid} !== 3'b000) begin
      errors++; $display("FAIL reset_out_valid: got %b expected 000", {bus1.out_valid, bus2.out_valid, bus4.out_valid});
    end
    checks++;
    if ((get1() | get2() | get4()) !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", get1() | get2() | get4());
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus1.in_ready, bus2.in_ready, bus4.in_ready} !== 3'b111) begin
      errors++; $display("FAIL post_reset_in_ready: got %b expected 111", {bus1.in_ready, bus2.in_ready, bus4.in_ready});
    end
  endtask

  task automatic test_known_vectors();
    vec_t vin [3];
    vec_t vexp [3];
    int k;
    vin[0] = VEC_A_IN;                    vexp[0] = VEC_A_OUT;
    vin[1] = '0;                          vexp[1] = {4{32'h63636363}};
    vin[2] = '1;                          vexp[2] = {4{32'h16161616}};
    for (int i = 0; i < 3; i++) begin
      send1(vin[i]);
      wait_valid1(k);
      checks++;
      if (k !== 4) begin
        errors++; $display("FAIL known_latency[%0d]: got %0d expected 4", i, k);
      end
      checks++;
      if (get1() !== vexp[i]) begin
        errors++; $display("FAIL known_data[%0d]: got %h expected %h", i, get1(), vexp[i]);
      end
      consume1();
    end
  endtask

  task automatic test_random();
    vec_t v, e;
    int k, d;
    for (int i = 0; i < 25; i++) begin
      v = rand_vec();
      e = model(v);
      send1(v);
      wait_valid1(k);
      checks++;
      if (k !== 4) begin
        errors++; $display("FAIL rand_latency[%0d]: got %0d expected 4", i, k);
      end
      d = $urandom_range(0, 3);
      for (int j = 0; j <= d; j++) begin
        checks++;
        if (get1() !== e || bus1.out_valid !== 1'b1) begin
          errors++; $display("FAIL rand_data[%0d]: got %h valid=%b expected %h valid=1", i, get1(), bus1.out_valid, e);
        end
        if (j < d) @(negedge clk);
      end
      consume1();
    end
  endtask

  task automatic test_backpressure();
    int k;
    send1(VEC_A_IN);
    wait_valid1(k);
    // New input presented while busy must be ignored.
    bus1.in_valid = 1'b1;
    {bus1.statew4, bus1.statew3, bus1.statew2, bus1.statew1} = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (bus1.out_valid !== 1'b1 || get1() !== VEC_A_OUT || bus1.in_ready !== 1'b0) begin
        errors++; $display("FAIL hold[%0d]: got valid=%b ready=%b data=%h expected valid=1 ready=0 data=%h",
                           i, bus1.out_valid, bus1.in_ready, get1(), VEC_A_OUT);
      end
    end
    bus1.in_valid = 1'b0;
    consume1();
    checks++;
    if (bus1.out_valid !== 1'b0 || bus1.in_ready !== 1'b1 || get1() !== '0) begin
      errors++; $display("FAIL release: got valid=%b ready=%b data=%h expected valid=0 ready=1 data=0",
                         bus1.out_valid, bus1.in_ready, get1());
    end
  endtask

  task automatic test_back_to_back();
    vec_t q_data [$];
    int   q_cyc [$];
    int   accepts;
    logic acc;
    accepts = 0;
    bus1.out_ready = 1'b1;
    @(negedge clk);
    {bus1.statew4, bus1.statew3, bus1.statew2, bus1.statew1} = VEC_A_IN;
    bus1.in_valid = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      acc = bus1.in_ready & bus1.in_valid;
      @(negedge clk);
      if (acc) begin
        accepts++;
        if (accepts == 1) {bus1.statew4, bus1.statew3, bus1.statew2, bus1.statew1} = '0;
        else bus1.in_valid = 1'b0;
      end
      if (bus1.out_valid) begin
        q_data.push_back(get1());
        q_cyc.push_back(cyc);
      end
    end
    bus1.in_valid = 1'b0;
    bus1.out_ready = 1'b0;
    checks++;
    if (accepts !== 2) begin
      errors++; $display("FAIL b2b_accepts: got %0d expected 2", accepts);
    end
    checks++;
    if (q_data.size() !== 2) begin
      errors++; $display("FAIL b2b_count: got %0d expected 2", q_data.size());
    end else begin
      checks++;
      if (q_data[0] !== VEC_A_OUT) begin
        errors++; $display("FAIL b2b_first: got %h expected %h", q_data[0], VEC_A_OUT);
      end
      checks++;
      if (q_data[1] !== {4{32'h63636363}}) begin
        errors++; $display("FAIL b2b_second: got %h expected %h", q_data[1], {4{32'h63636363}});
      end
      checks++;
      if (q_cyc[1] - q_cyc[0] !== 6) begin
        errors++; $display("FAIL b2b_spacing: got %0d expected 6", q_cyc[1] - q_cyc[0]);
      end
    end
  endtask

  task automatic test_reset_midop();
    int   k;
    logic seen;
    send1(VEC_A_IN);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus1.out_valid !== 1'b0 || get1() !== '0 || bus1.in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_sub: got valid=%b ready=%b data=%h expected 0 0 0", bus1.out_valid, bus1.in_ready, get1());
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus1.in_ready !== 1'b1 || bus1.out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_sub_idle: got ready=%b valid=%b expected 1 0", bus1.in_ready, bus1.out_valid);
    end
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus1.out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL rst_sub_partial: got out_valid seen=%b expected 0", seen);
    end
    send1(VEC_A_IN);
    wait_valid1(k);
    checks++;
    if (bus1.out_valid !== 1'b1) begin
      errors++; $display("FAIL rst_done_reach: got valid=%b expected 1 (timeout)", bus1.out_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus1.out_valid !== 1'b0 || get1() !== '0) begin
      errors++; $display("FAIL rst_done: got valid=%b data=%h expected 0 0", bus1.out_valid, get1());
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus1.in_ready !== 1'b1 || bus1.out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_done_idle: got ready=%b valid=%b expected 1 0", bus1.in_ready, bus1.out_valid);
    end
  endtask

  task automatic test_cols_per_cycle();
    vec_t v, e;
    int   k2, k4;
    for (int it = 0; it < 4; it++) begin
      v = (it == 0) ? VEC_A_IN : rand_vec();
      e = (it == 0) ? VEC_A_OUT : model(v);
      @(negedge clk);
      {bus2.statew4, bus2.statew3, bus2.statew2, bus2.statew1} = v;
      {bus4.statew4, bus4.statew3, bus4.statew2, bus4.statew1} = v;
      bus2.in_valid = 1'b1;
      bus4.in_valid = 1'b1;
      @(negedge clk);
      bus2.in_valid = 1'b0;
      bus4.in_valid = 1'b0;
      k2 = -1; k4 = -1;
      for (int k = 0; k < 12; k++) begin
        if (k2 < 0 && bus2.out_valid) k2 = k;
        if (k4 < 0 && bus4.out_valid) k4 = k;
        if (k2 >= 0 && k4 >= 0) break;
        @(negedge clk);
      end
      checks++;
      if (k2 !== 2) begin
        errors++; $display("FAIL cpc2_latency[%0d]: got %0d expected 2", it, k2);
      end
      checks++;
      if (k4 !== 1) begin
        errors++; $display("FAIL cpc4_latency[%0d]: got %0d expected 1", it, k4);
      end
      checks++;
      if (get2() !== e) begin
        errors++; $display("FAIL cpc2_data[%0d]: got %h expected %h", it, get2(), e);
      end
      checks++;
      if (get4() !== e) begin
        errors++; $display("FAIL cpc4_data[%0d]: got %h expected %h", it, get4(), e);
      end
      bus2.out_ready = 1'b1;
      bus4.out_ready = 1'b1;
      @(negedge clk);
      bus2.out_ready = 1'b0;
      bus4.out_ready = 1'b0;
    end
  endtask

  task automatic test_out_ready_idle();
    bus1.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus1.out_valid !== 1'b0 || get1() !== '0 || bus1.in_ready !== 1'b1) begin
      errors++; $display("FAIL ready_idle: got valid=%b ready=%b data=%h expected 0 1 0", bus1.out_valid, bus1.in_ready, get1());
    end
    bus1.out_ready = 1'b0;
  endtask

  initial begin
    VEC_A_IN  = mk(32'h193de3be, 32'ha0f4e22b, 32'h9ac68d2a, 32'he9f84808);
    VEC_A_OUT = mk(32'hd4bf5d30, 32'he0b452ae, 32'hb84111f1, 32'h1e2798e5);
    build_sref();
    test_reset();
    test_known_vectors();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    test_cols_per_cycle();
    test_out_ready_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
